// File: rtl/sseg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package sseg_pkg;

    // Active-low segment patterns, bit7 = dp, bits 6:0 = g..a
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic {IDLE, CONV} state_t;

    // Number of BCD digits needed to hold any WIDTH-bit binary value
    function automatic int unsigned bcd_digits(input int unsigned width);
        return (width * 3) / 10 + 1;
    endfunction

    // Hex digit to active-low glyph with the decimal point off
    function automatic logic [7:0] hex_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// `done` and `bcd` are combinational: they carry the result of the final
// iteration during the cycle whose closing edge performs it, so the consumer
// can capture the result on the same edge that drops `busy`.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BCD_DIGITS = bcd_digits(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t                  state_q;
    logic [WIDTH-1:0]        bin_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] bcd_adj;
    logic [CW-1:0]           cnt_q;
    logic                    unused_msb;

    // One iteration: add 3 to every digit >= 5, then shift in the next value MSB
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[WIDTH-1]};
    end

    // The top BCD bit never carries out for a correctly sized register
    assign unused_msb = bcd_adj[4*BCD_DIGITS-1];

    assign busy = (state_q == CONV);
    assign done = (state_q == CONV) && (cnt_q == CW'(WIDTH - 1));

    // Conversion FSM: latch on start, iterate WIDTH times, return to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment display controller: hex or decimal display of a
// captured value with leading-zero blanking, decimal points and overflow dashes.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic [7:0]        sseg,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned BCD_DIGITS = bcd_digits(WIDTH);
    localparam int unsigned NIBBLES    = (WIDTH + 3) / 4;
    localparam int unsigned HEXN       = (NIBBLES > DIGITS) ? NIBBLES : DIGITS;
    localparam int unsigned BCDN       = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
    localparam int unsigned IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0]     disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [4*HEXN-1:0]       hex_pad;
    logic [4*BCDN-1:0]       bcd_pad;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    conv_done;
    logic                    load_hex, start_dec;

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [IDXW-1:0]         scan_q;

    logic [DIGITS-1:0]       upper_zero;
    logic [3:0]              cur_digit;
    logic [7:0]              glyph;
    logic                    dp_on;
    logic [7:0]              sseg_d;
    logic [DIGITS-1:0]       an_d;

    // A load is only honoured while no conversion is running; no queueing
    assign load_hex  = load && !busy && !mode;
    assign start_dec = load && !busy && mode;

    bin2bcd_seq #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_dec),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Next display contents: whole register replaced at once on hex load or conversion end
    always_comb begin
        hex_pad                    = '0;
        hex_pad[WIDTH-1:0]         = value;
        bcd_pad                    = '0;
        bcd_pad[4*BCD_DIGITS-1:0]  = bcd;
        disp_d                     = disp_q;
        ovf_d                      = ovf_q;
        if (load_hex) begin
            disp_d = hex_pad[4*DIGITS-1:0];
            ovf_d  = |(hex_pad >> (4 * DIGITS));
        end else if (conv_done) begin
            disp_d = bcd_pad[4*DIGITS-1:0];
            ovf_d  = |(bcd_pad >> (4 * DIGITS));
        end
    end

    // Display register and overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    // Free-running refresh counter; scan index steps on every counter wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            scan_q    <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            if (&refresh_q) begin
                scan_q <= (scan_q == IDXW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
            end
        end
    end

    // upper_zero[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        int j;
        upper_zero             = '0;
        upper_zero[DIGITS-1]   = (disp_q[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = 0; i < int'(DIGITS) - 1; i++) begin
            j             = int'(DIGITS) - 2 - i;
            upper_zero[j] = upper_zero[j+1] && (disp_q[4*j +: 4] == 4'd0);
        end
    end

    // Segment and anode selection for the current scan index
    always_comb begin
        cur_digit = disp_q[4*scan_q +: 4];
        glyph     = hex_glyph(cur_digit);
        dp_on     = dp_mask[scan_q];
        if (ovf_q) begin
            sseg_d = {~dp_on, SEG_DASH[6:0]};
        end else if (blank_lz && (scan_q != '0) && upper_zero[scan_q]) begin
            sseg_d = SEG_BLANK;
        end else begin
            sseg_d = {~dp_on, glyph[6:0]};
        end
        an_d         = '1;
        an_d[scan_q] = 1'b0;
    end

    // Segments and anodes registered together so they always switch on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sseg <= SEG_BLANK;
            an   <= '1;
        end else begin
            sseg <= sseg_d;
            an   <= an_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed, self-checking bench for sseg_scan_ctrl with a small scoreboard of
// expected {anode, glyph} pairs for a 4-digit and a 2-digit instance.
module tb_sseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       mode = 1'b0;
    logic       blank_lz = 1'b0;
    logic [7:0] value = 8'h00;
    logic [3:0] dp_mask = 4'b0000;
    logic [1:0] dp_mask2 = 2'b00;

    logic       busy, busy2;
    logic [7:0] sseg, sseg2;
    logic [3:0] an;
    logic [1:0] an2;

    int compared = 0;
    int mism = 0;

    typedef struct packed {
        logic       which;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .busy     (busy),
        .sseg     (sseg),
        .an       (an)
    );

    sseg_scan_ctrl #(.WIDTH(8), .DIGITS(2), .REFRESH_BITS(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask2),
        .busy     (busy2),
        .sseg     (sseg2),
        .an       (an2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic which, input int p, input logic [7:0] g);
        exp_t e;
        logic [3:0] onehot;
        onehot  = 4'b0001 << p;
        e.which = which;
        e.an    = ~onehot;
        e.seg   = g;
        sb.push_back(e);
    endtask

    task automatic push4(input logic [7:0] g0, input logic [7:0] g1,
                         input logic [7:0] g2, input logic [7:0] g3);
        push(1'b0, 0, g0);
        push(1'b0, 1, g1);
        push(1'b0, 2, g2);
        push(1'b0, 3, g3);
    endtask

    // Pop each entry, wait (bounded) for its digit to be scanned, compare the glyph
    task automatic drain_wait(input string tag);
        exp_t e;
        int n;
        logic [3:0] an_obs;
        logic [7:0] seg_obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            an_obs = e.which ? {2'b11, an2} : an;
            while (an_obs !== e.an && n < 32) begin
                @(negedge clk);
                n++;
                an_obs = e.which ? {2'b11, an2} : an;
            end
            seg_obs = e.which ? sseg2 : sseg;
            chk({tag, "_an"}, {4'h0, an_obs}, {4'h0, e.an});
            chk({tag, "_seg"}, seg_obs, e.seg);
        end
    endtask

    // Pop one entry per cycle and compare exactly at that cycle
    task automatic drain_strict(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_an"}, {4'h0, an}, {4'h0, e.an});
            chk({tag, "_seg"}, sseg, e.seg);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 8'(busy), 8'h00);
    endtask

    task automatic pulse_load(input logic [7:0] v, input logic m);
        value = v;
        mode  = m;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        logic [7:0] old_g[4];
        int p;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_sseg", sseg, 8'hFF);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_an2", {6'h0, an2}, 8'h03);
        reset = 1'b0;
        @(negedge clk);

        // Scan order after release, each digit for 4 cycles
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) push(1'b0, d, 8'hC0);
        end
        drain_strict("scan");

        // Hex load of A5 with blanking; busy must stay low
        blank_lz = 1'b1;
        pulse_load(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("hex_busy", 8'(busy), 8'h00);
            @(negedge clk);
        end
        push4(8'h92, 8'h88, 8'hFF, 8'hFF);
        drain_wait("hexA5");

        // Decimal 255: busy for exactly 8 cycles, old value shown meanwhile
        old_g[0] = 8'h92;
        old_g[1] = 8'h88;
        old_g[2] = 8'hFF;
        old_g[3] = 8'hFF;
        pulse_load(8'd255, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("dec_busy_hi", 8'(busy), 8'h01);
            p = 0;
            for (int i = 0; i < 4; i++) if (an[i] === 1'b0) p = i;
            chk("dec_old", sseg, old_g[p]);
            @(negedge clk);
        end
        chk("dec_busy_lo", 8'(busy), 8'h00);
        push4(8'h92, 8'h92, 8'hA4, 8'hFF);
        drain_wait("dec255");

        // Decimal 200: fits four digits, overflows two digits
        pulse_load(8'd200, 1'b1);
        wait_idle("dec200");
        push4(8'hC0, 8'hC0, 8'hA4, 8'hFF);
        push(1'b1, 0, 8'hBF);
        push(1'b1, 1, 8'hBF);
        drain_wait("dec200");

        // Decimal 7 with a load of 9 during busy that must be dropped
        pulse_load(8'd7, 1'b1);
        repeat (2) @(negedge clk);
        pulse_load(8'd9, 1'b1);
        chk("ign_busy", 8'(busy), 8'h01);
        wait_idle("dec7");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ign_noqueue", 8'(busy), 8'h00);
        end
        push4(8'hF8, 8'hFF, 8'hFF, 8'hFF);
        drain_wait("dec7");

        // Reset in the middle of a conversion
        pulse_load(8'd7, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_busy", 8'(busy), 8'h01);
        reset = 1'b1;
        #1;
        chk("mid_rst_an", {4'h0, an}, 8'h0F);
        chk("mid_rst_sseg", sseg, 8'hFF);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_an", {4'h0, an}, 8'h0E);
        chk("post_rst_sseg", sseg, 8'hC0);

        // Decimal point on digit 1, then blanking overrides it
        blank_lz = 1'b0;
        dp_mask  = 4'b0010;
        pulse_load(8'h00, 1'b0);
        @(negedge clk);
        push4(8'hC0, 8'h40, 8'hC0, 8'hC0);
        drain_wait("dp");
        blank_lz = 1'b1;
        @(negedge clk);
        push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        drain_wait("dp_blank");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
